// File: rtl/xc_malu_mul_seq_pkg.sv
// Shared definitions for the shift/add multiply sequencer: state encoding,
// step-count sizing and the op-decode helper reused by packed controllers.
package xc_malu_mul_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int COUNT_W   = 6;
    localparam int MUL_STEPS = 32;

    typedef struct packed {
        logic hi;
        logic carryless;
        logic lhs_sign;
        logic rhs_sign;
    } mul_ctl_t;

    // plain mul selects the low half and is unsigned in both operands
    function automatic mul_ctl_t mul_decode(
        input logic mulh,
        input logic mulhu,
        input logic mulhsu,
        input logic clmul,
        input logic clmulh
    );
        mul_ctl_t ctl;
        ctl.hi        = mulh | mulhu | mulhsu | clmulh;
        ctl.carryless = clmul | clmulh;
        ctl.lhs_sign  = mulh | mulhsu;
        ctl.rhs_sign  = mulh;
        return ctl;
    endfunction

endpackage

// File: rtl/xc_malu_mul_seq.sv
// Sequencer for the single-step shift/add multiplier: owns count/acc/arg_0,
// steps the external datapath once per cycle and returns the selected half.
module xc_malu_mul_seq
    import xc_malu_mul_seq_pkg::*;
#(
    parameter bit RESULT_REG = 1'b1
) (
    input  logic               g_clk,
    input  logic               g_reset,
    input  logic               valid,
    input  logic               flush,
    input  logic [31:0]        rs1,
    input  logic [31:0]        rs2,
    input  logic               op_mul,
    input  logic               op_mulh,
    input  logic               op_mulhu,
    input  logic               op_mulhsu,
    input  logic               op_clmul,
    input  logic               op_clmulh,
    output logic               ready,
    output logic [31:0]        result,
    output logic               busy,
    output logic [COUNT_W-1:0] stp_count,
    output logic [63:0]        stp_acc,
    output logic [31:0]        stp_arg_0,
    output logic [31:0]        stp_rs1,
    output logic               stp_carryless,
    output logic               stp_lhs_sign,
    output logic               stp_rhs_sign,
    output logic               stp_pw_32,
    output logic               stp_pw_16,
    output logic               stp_pw_8,
    output logic               stp_pw_4,
    output logic               stp_pw_2,
    input  logic [63:0]        stp_n_acc,
    input  logic [31:0]        stp_n_arg_0,
    input  logic               stp_ready
);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [63:0]        acc;
    logic [31:0]        arg_0;
    logic [31:0]        rs1_q;
    logic [31:0]        result_reg;
    mul_ctl_t           ctl;
    mul_ctl_t           ctl_in;
    logic [31:0]        acc_half;
    logic               finish;

    assign ctl_in   = mul_decode(op_mulh, op_mulhu, op_mulhsu, op_clmul, op_clmulh);
    assign acc_half = ctl.hi ? acc[63:32] : acc[31:0];
    assign finish   = (state == S_RUN) && stp_ready && !flush;

    // flush has priority over every transition, including the final step
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state      <= S_IDLE;
            count      <= '0;
            acc        <= '0;
            arg_0      <= '0;
            rs1_q      <= '0;
            result_reg <= '0;
            ctl        <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (valid) begin
                        state <= S_RUN;
                        count <= '0;
                        acc   <= '0;
                        arg_0 <= rs2;
                        rs1_q <= rs1;
                        ctl   <= ctl_in;
                    end
                end
                S_RUN: begin
                    if (stp_ready) begin
                        result_reg <= acc_half;
                        state      <= RESULT_REG ? S_DONE : S_IDLE;
                    end else begin
                        acc   <= stp_n_acc;
                        arg_0 <= stp_n_arg_0;
                        count <= count + COUNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        if (RESULT_REG) begin
            ready = (state == S_DONE) && !flush;
        end else begin
            ready = finish;
        end
    end

    assign result        = ready ? (RESULT_REG ? result_reg : acc_half) : '0;
    assign busy          = (state != S_IDLE);
    assign stp_count     = count;
    assign stp_acc       = acc;
    assign stp_arg_0     = arg_0;
    assign stp_rs1       = rs1_q;
    assign stp_carryless = ctl.carryless;
    assign stp_lhs_sign  = ctl.lhs_sign;
    assign stp_rhs_sign  = ctl.rhs_sign;
    assign stp_pw_32     = 1'b1;
    assign stp_pw_16     = 1'b0;
    assign stp_pw_8      = 1'b0;
    assign stp_pw_4      = 1'b0;
    assign stp_pw_2      = 1'b0;

    // mixed op selects on an accepted request have no defined result
    op_onehot_at_accept: assert property (
        @(posedge g_clk) disable iff (g_reset)
        (valid && !flush && state == S_IDLE) |->
            $onehot({op_mul, op_mulh, op_mulhu, op_mulhsu, op_clmul, op_clmulh})
    );

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// Scoreboard bench for xc_malu_mul_seq with a behavioural step datapath that
// accumulates shifted partial products (subtracting the signed top bit).
module tb_xc_malu_mul_seq;

    localparam logic [5:0] OP_MUL    = 6'b100000;
    localparam logic [5:0] OP_MULH   = 6'b010000;
    localparam logic [5:0] OP_MULHU  = 6'b001000;
    localparam logic [5:0] OP_MULHSU = 6'b000100;
    localparam logic [5:0] OP_CLMUL  = 6'b000010;
    localparam logic [5:0] OP_CLMULH = 6'b000001;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        valid;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  ops;
    logic        ready;
    logic [31:0] result;
    logic        busy;
    logic [5:0]  stp_count;
    logic [63:0] stp_acc;
    logic [31:0] stp_arg_0;
    logic [31:0] stp_rs1;
    logic        stp_carryless;
    logic        stp_lhs_sign;
    logic        stp_rhs_sign;
    logic        stp_pw_32;
    logic        stp_pw_16;
    logic        stp_pw_8;
    logic        stp_pw_4;
    logic        stp_pw_2;
    logic [63:0] stp_n_acc;
    logic [31:0] stp_n_arg_0;
    logic        stp_ready;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc <= cyc + 1;

    xc_malu_mul_seq #(.RESULT_REG(1'b1)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .flush(flush),
        .rs1(rs1), .rs2(rs2),
        .op_mul(ops[5]), .op_mulh(ops[4]), .op_mulhu(ops[3]),
        .op_mulhsu(ops[2]), .op_clmul(ops[1]), .op_clmulh(ops[0]),
        .ready(ready), .result(result), .busy(busy),
        .stp_count(stp_count), .stp_acc(stp_acc), .stp_arg_0(stp_arg_0),
        .stp_rs1(stp_rs1), .stp_carryless(stp_carryless),
        .stp_lhs_sign(stp_lhs_sign), .stp_rhs_sign(stp_rhs_sign),
        .stp_pw_32(stp_pw_32), .stp_pw_16(stp_pw_16), .stp_pw_8(stp_pw_8),
        .stp_pw_4(stp_pw_4), .stp_pw_2(stp_pw_2),
        .stp_n_acc(stp_n_acc), .stp_n_arg_0(stp_n_arg_0), .stp_ready(stp_ready)
    );

    // behavioural step datapath: step i adds rs1 * rs2[i] * 2^i
    logic [63:0] lhs_ext;
    logic [63:0] pp;
    always_comb begin
        lhs_ext = stp_lhs_sign ? {{32{stp_rs1[31]}}, stp_rs1} : {32'b0, stp_rs1};
        pp      = stp_arg_0[0] ? (lhs_ext << stp_count) : 64'd0;
        if (stp_carryless) begin
            stp_n_acc = stp_acc ^ pp;
        end else if (stp_rhs_sign && stp_count == 6'd31) begin
            stp_n_acc = stp_acc - pp;
        end else begin
            stp_n_acc = stp_acc + pp;
        end
        stp_n_arg_0 = stp_arg_0 >> 1;
        stp_ready   = (stp_count == 6'd32);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // monitor: every ready pulse must match the oldest outstanding op
    always @(negedge g_clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ready: got result 0x%0h at cycle %0d, expected no ready",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, 64'(result), 64'(e.res));
                checkOutput({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issueOnly(input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        valid = 1'b1;
        ops   = op;
        rs1   = a;
        rs2   = b;
    endtask

    // issues in the current (IDLE) cycle; ready expected 34 cycles later
    task automatic applyStimulus(input string name, input logic [5:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected);
        exp_t e;
        bit   seen;
        e.res  = expected;
        e.cyc  = cyc + 34;
        e.name = name;
        sb.push_back(e);
        issueOnly(op, a, b);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge g_clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: got no ready in 60 cycles, expected ready", name);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        valid = 1'b0;
        ops   = '0;
        repeat (n) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_ready"}, 64'(ready), 64'd0);
        checkOutput({tag, "_result"}, 64'(result), 64'd0);
        checkOutput({tag, "_count"}, 64'(stp_count), 64'd0);
        checkOutput({tag, "_acc"}, stp_acc, 64'd0);
        checkOutput({tag, "_arg_0"}, 64'(stp_arg_0), 64'd0);
        checkOutput({tag, "_flags"}, 64'({stp_carryless, stp_lhs_sign, stp_rhs_sign}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        g_reset = 1'b1;
        valid   = 1'b0;
        flush   = 1'b0;
        ops     = '0;
        rs1     = '0;
        rs2     = '0;
        repeat (3) @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        checkAllZero("reset");
        checkOutput("reset_pw", 64'({stp_pw_32, stp_pw_16, stp_pw_8, stp_pw_4, stp_pw_2}), 64'h10);

        applyStimulus("mul_3x5", OP_MUL, 32'd3, 32'd5, 32'h0000000F);
        idleCycles(2);
        // back-to-back with valid held: each ready lands 35 cycles after the last
        applyStimulus("mulh_m1", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        applyStimulus("mul_m1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        applyStimulus("mulhu_m1", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        applyStimulus("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        idleCycles(1);
        applyStimulus("clmul", OP_CLMUL, 32'd3, 32'd3, 32'h00000005);
        applyStimulus("clmulh", OP_CLMULH, 32'h80000000, 32'd2, 32'h00000001);

        // flush partway through; the op must never report ready
        idleCycles(1);
        issueOnly(OP_MUL, 32'd9, 32'd9);
        repeat (10) begin
            @(posedge g_clk);
            #1;
        end
        flush = 1'b1;
        valid = 1'b0;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        applyStimulus("mul_after_flush", OP_MUL, 32'd7, 32'd6, 32'h0000002A);

        // flush while idle swallows the request
        idleCycles(1);
        issueOnly(OP_MUL, 32'd2, 32'd2);
        flush = 1'b1;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        checkOutput("idle_flush_busy", 64'(busy), 64'd0);

        // flush coincides with stp_ready: no result
        idleCycles(1);
        issueOnly(OP_MULHU, 32'h12345678, 32'h9ABCDEF0);
        repeat (33) begin
            @(posedge g_clk);
            #1;
        end
        checkOutput("last_step_count", 64'(stp_count), 64'd32);
        flush = 1'b1;
        valid = 1'b0;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_ready_busy", 64'(busy), 64'd0);
        idleCycles(3);

        // reset mid-op returns every register to its reset value
        issueOnly(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (20) begin
            @(posedge g_clk);
            #1;
        end
        g_reset = 1'b1;
        valid   = 1'b0;
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        checkAllZero("midreset");

        applyStimulus("mulhu_after_reset", OP_MULHU, 32'h80000000, 32'd4, 32'h00000002);
        idleCycles(3);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
